// File: rtl/mul_arb_pkg.sv
// mul_arb_pkg: shared definitions for the multiplier arbiter.
//   state_t      - sequencer states (IDLE, ISSUE, WAIT, RESP)
//   OP_W         - operand width of the shared multiplier
//   PROD_W       - product width returned to requesters
//   DEF_TIMEOUT  - default watchdog limit in WAIT cycles
package mul_arb_pkg;

    localparam int OP_W        = 16;
    localparam int PROD_W      = 32;
    localparam int DEF_TIMEOUT = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/mul_arbiter_rr_picker.sv
// rr_picker: combinational round-robin select.
// Searches valid upward starting at ptr, wrapping at N, and returns the
// first requester found.
//   valid  in  N     request lines
//   ptr    in  ID_W  highest-priority index this cycle (always < N)
//   grant  out N     one-hot winner (zero when nothing is valid)
//   id     out ID_W  encoded winner
//   any    out 1     at least one request is valid
module rr_picker #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    valid,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] id,
    output logic            any
);

    logic found;
    int   idx;

    assign any = |valid;

    always_comb begin
        grant = '0;
        id    = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                id         = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// mul_arbiter: shares one sequential 16x16 signed multiplier between
// NUM_REQ requesters, round-robin, one multiply in flight at a time.
//   clk, rst            clock (rising edge), async active-high reset
//   req_valid/ready     per-requester request handshake (ready is one-hot)
//   req_a, req_b        packed operands, requester i at [16i+15:16i]
//   rsp_valid/ready     response handshake
//   rsp_id, rsp_result  requester id and 32-bit product
//   rsp_err             watchdog abort flag (constant 0 unless enabled)
//   mul_a, mul_b        operands to the multiplier, held from ISSUE to WAIT
//   mul_start           one-cycle start pulse (high during ISSUE)
//   mul_done            multiplier done level, sampled in WAIT
//   mul_result          multiplier product
//   dbg_state           current sequencer state
// Build option: define MUL_ARB_TIMEOUT_EN to add the WAIT watchdog.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. valid never depends on ready. req_ready is only ever raised in
// IDLE, for the single winner; rsp_valid is raised only in RESP and the
// response fields stay constant until the transfer.
module mul_arbiter
    import mul_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*OP_W-1:0] req_a,
    input  logic [NUM_REQ*OP_W-1:0] req_b,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    rsp_valid,
    output logic [ID_W-1:0]         rsp_id,
    output logic [PROD_W-1:0]       rsp_result,
    output logic                    rsp_err,
    input  logic                    rsp_ready,
    output logic [OP_W-1:0]         mul_a,
    output logic [OP_W-1:0]         mul_b,
    output logic                    mul_start,
    input  logic                    mul_done,
    input  logic [PROD_W-1:0]       mul_result,
    output state_t                  dbg_state
);

    state_t              state, state_next;
    logic [ID_W-1:0]     rr_ptr;
    logic [NUM_REQ-1:0]  pick_grant;
    logic [ID_W-1:0]     pick_id;
    logic                pick_any;
    logic                take;
    logic                timed_out;

    rr_picker #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_picker (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .id    (pick_id),
        .any   (pick_any)
    );

    assign dbg_state = state;
    assign take      = (state == IDLE) && pick_any;

`ifdef MUL_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;

    // Counter value c means c WAIT cycles already elapsed before this one,
    // so firing at TIMEOUT-1 gives exactly TIMEOUT WAIT cycles.
    assign timed_out = (state == WAIT) && !mul_done &&
                       (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == ISSUE) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
    assign timed_out      = 1'b0;
    assign rsp_err        = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = '0;
        mul_start  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    req_ready  = pick_grant;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                mul_start  = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (mul_done || timed_out) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr     <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            rsp_id     <= '0;
            rsp_result <= '0;
        end else begin
            if (take) begin
                mul_a  <= req_a[pick_id*OP_W +: OP_W];
                mul_b  <= req_b[pick_id*OP_W +: OP_W];
                rsp_id <= pick_id;
                rr_ptr <= (pick_id == ID_W'(NUM_REQ - 1)) ? '0 : pick_id + 1'b1;
            end
            if (state == WAIT && mul_done) begin
                rsp_result <= mul_result;
            end else if (timed_out) begin
                rsp_result <= '0;
            end
        end
    end

`ifdef MUL_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_err <= 1'b0;
        end else if (state == WAIT && mul_done) begin
            rsp_err <= 1'b0;
        end else if (timed_out) begin
            rsp_err <= 1'b1;
        end
    end
`endif

endmodule
